// File: rtl/snn_ff_pkg.sv
// Shared types and helpers for the Forward-Forward goodness path.
package snn_ff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } good_state_e;

  typedef enum logic {
    GOOD_SRC_SCNT = 1'b0,
    GOOD_SRC_MEM  = 1'b1
  } good_src_e;

  // Lane value width: wide enough for a spike count or a non-negative membrane.
  function automatic int lane_width(input int scnt_w, input int mem_w);
    return (scnt_w > mem_w - 1) ? scnt_w : mem_w - 1;
  endfunction

endpackage

// File: rtl/goodness_accum_if.sv
// Read-out buses from the neuron core plus the result handshake to the
// learning controller.
interface goodness_accum_if #(
  parameter int PARALLEL = 4,
  parameter int MEM_W    = 12,
  parameter int SCNT_W   = 7,
  parameter int ACC_W    = 32
);
  logic                       good_start;
  logic                       good_sel;
  logic                       good_in_valid;
  logic [SCNT_W*PARALLEL-1:0] post_neur_s_cnt;
  logic [MEM_W*PARALLEL-1:0]  post_neur_mem_bus;
  logic [ACC_W-1:0]           good_thr;
  logic                       good_busy;
  logic [ACC_W-1:0]           goodness;
  logic                       good_pos;
  logic                       good_valid;
  logic                       good_ready;

  modport master (
    output good_start, good_sel, good_in_valid, post_neur_s_cnt,
           post_neur_mem_bus, good_thr, good_ready,
    input  good_busy, goodness, good_pos, good_valid
  );

  modport slave (
    input  good_start, good_sel, good_in_valid, post_neur_s_cnt,
           post_neur_mem_bus, good_thr, good_ready,
    output good_busy, goodness, good_pos, good_valid
  );
endinterface

// File: rtl/goodness_lane.sv
// One lane: source select with ReLU, then registered value (S1) and
// registered square (S2). Validity is tracked by the parent.
module goodness_lane
  import snn_ff_pkg::*;
#(
  parameter int SCNT_W = 7,
  parameter int MEM_W  = 12,
  parameter int LW     = lane_width(SCNT_W, MEM_W)
) (
  input  logic              clk_i,
  input  good_src_e         sel_i,
  input  logic [SCNT_W-1:0] scnt_i,
  input  logic [MEM_W-1:0]  mem_i,
  output logic [2*LW-1:0]   sq_o
);
  localparam int SQ_W = 2 * LW;

  logic [LW-1:0]   val_d;
  logic [LW-1:0]   val_q;
  logic [SQ_W-1:0] sq_q;

  // Pick spike count or ReLU(membrane) for this lane.
  always_comb begin
    // NOTE: default assigned first so every path drives val_d; no latch.
    val_d = LW'(scnt_i);
    if (sel_i == GOOD_SRC_MEM) begin
      val_d = mem_i[MEM_W-1] ? '0 : LW'(mem_i[MEM_W-2:0]);
    end
  end

  // S1 value and S2 square registers; they advance every cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so both stages sample pre-edge values.
    // NOTE: pure datapath, no reset; the parent's stage valids gate its use.
    val_q <= val_d;
    sq_q  <= SQ_W'(val_q) * SQ_W'(val_q);
  end

  assign sq_o = sq_q;

endmodule

// File: rtl/goodness_accum.sv
// Squares and accumulates post-neuron activity over one sweep, then offers
// the saturated goodness and its threshold compare over valid/ready.
module goodness_accum
  import snn_ff_pkg::*;
#(
  parameter int OUTPUT_NEURON             = 256,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int ACC_WIDTH                 = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  goodness_accum_if.slave  bus
);
  localparam int NWORDS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int BW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LW     = lane_width(POST_NEUR_SPIKE_CNT_WIDTH, POST_NEUR_MEM_WIDTH);
  localparam int SQ_W   = 2 * LW;
  localparam int SUM_W  = SQ_W + $clog2(POST_NEUR_PARALLEL);
  localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  good_state_e          state_q, state_d;
  good_src_e            sel_q;
  logic [ACC_WIDTH-1:0] thr_q;
  logic [BW-1:0]        beat_cnt_q;
  logic                 s1_v_q, s2_v_q, s3_v_q;
  logic [SQ_W-1:0]      sq [POST_NEUR_PARALLEL];
  logic [SUM_W-1:0]     sum_d, sum_q;
  logic [EXT_W-1:0]     acc_ext;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 good_valid_q, good_pos_q;
  logic [ACC_WIDTH-1:0] goodness_q;
  logic                 start_acc, beat_accept, load_result, result_taken;

  for (genvar i = 0; i < POST_NEUR_PARALLEL; i++) begin : g_lane
    goodness_lane #(
      .SCNT_W (POST_NEUR_SPIKE_CNT_WIDTH),
      .MEM_W  (POST_NEUR_MEM_WIDTH)
    ) u_lane (
      .clk_i  (CLK),
      .sel_i  (sel_q),
      .scnt_i (bus.post_neur_s_cnt[i*POST_NEUR_SPIKE_CNT_WIDTH +: POST_NEUR_SPIKE_CNT_WIDTH]),
      .mem_i  (bus.post_neur_mem_bus[i*POST_NEUR_MEM_WIDTH +: POST_NEUR_MEM_WIDTH]),
      .sq_o   (sq[i])
    );
  end

  // Lane sum feeding S3, and the saturating accumulate of S3.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < POST_NEUR_PARALLEL; i++) begin
      sum_d = sum_d + SUM_W'(sq[i]);
    end
    acc_ext = EXT_W'(acc_q) + EXT_W'(sum_q);
    acc_d   = (|acc_ext[EXT_W-1:ACC_WIDTH]) ? '1 : acc_ext[ACC_WIDTH-1:0];
  end

  // Sweep sequencing: next state and one-cycle control strobes.
  always_comb begin
    state_d      = state_q;
    start_acc    = 1'b0;
    beat_accept  = 1'b0;
    load_result  = 1'b0;
    result_taken = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.good_start) begin
          start_acc = 1'b1;
          state_d   = ACC;
        end
      end
      ACC: begin
        if (bus.good_in_valid) begin
          beat_accept = 1'b1;
          if (beat_cnt_q == BW'(NWORDS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!(s1_v_q || s2_v_q || s3_v_q)) begin
          load_result = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.good_ready) begin
          result_taken = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sweep configuration, beat counter, stage valids and accumulator.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sel_q      <= GOOD_SRC_SCNT;
      thr_q      <= '0;
      beat_cnt_q <= '0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_v_q <= beat_accept;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
      if (start_acc) begin
        sel_q      <= good_src_e'(bus.good_sel);
        thr_q      <= bus.good_thr;
        beat_cnt_q <= '0;
        acc_q      <= '0;
      end else begin
        if (beat_accept) beat_cnt_q <= beat_cnt_q + BW'(1);
        if (s3_v_q)      acc_q      <= acc_d;
      end
    end
  end

  // S3 lane-sum data register.
  always_ff @(posedge CLK) begin
    sum_q <= sum_d;
  end

  // Registered result, held stable until the consumer takes it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      good_valid_q <= 1'b0;
      good_pos_q   <= 1'b0;
      goodness_q   <= '0;
    end else if (load_result) begin
      good_valid_q <= 1'b1;
      good_pos_q   <= (acc_q >= thr_q);
      goodness_q   <= acc_q;
    end else if (result_taken) begin
      good_valid_q <= 1'b0;
    end
  end

  assign bus.good_busy  = (state_q == ACC) || (state_q == DRAIN);
  assign bus.good_valid = good_valid_q;
  assign bus.good_pos   = good_pos_q;
  assign bus.goodness   = goodness_q;

endmodule

// File: tb/tb_goodness_accum.sv
// Bench for goodness_accum: two instances (32-bit and 20-bit accumulator)
// share one stimulus; expected goodness comes from a sum-of-squares model.
module tb_goodness_accum;
  localparam int NW = 64;
  localparam int P  = 4;
  localparam int SW = 7;
  localparam int MW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          ready = 1'b0;
  logic [SW*P-1:0] scnt = '0;
  logic [MW*P-1:0] mem = '0;
  logic [31:0]   thr = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [SW-1:0] scnt_w [NW][P];
  logic [MW-1:0] mem_w  [NW][P];

  goodness_accum_if #(.PARALLEL(P), .MEM_W(MW), .SCNT_W(SW), .ACC_W(32)) if_a ();
  goodness_accum_if #(.PARALLEL(P), .MEM_W(MW), .SCNT_W(SW), .ACC_W(20)) if_b ();

  assign if_a.good_start        = start;
  assign if_a.good_sel          = sel;
  assign if_a.good_in_valid     = in_valid;
  assign if_a.post_neur_s_cnt   = scnt;
  assign if_a.post_neur_mem_bus = mem;
  assign if_a.good_thr          = thr;
  assign if_a.good_ready        = ready;
  assign if_b.good_start        = start;
  assign if_b.good_sel          = sel;
  assign if_b.good_in_valid     = in_valid;
  assign if_b.post_neur_s_cnt   = scnt;
  assign if_b.post_neur_mem_bus = mem;
  assign if_b.good_thr          = thr[19:0];
  assign if_b.good_ready        = ready;

  goodness_accum #(.ACC_WIDTH(32)) dut_a (.CLK(clk), .RST_N(rst_n), .bus(if_a));
  goodness_accum #(.ACC_WIDTH(20)) dut_b (.CLK(clk), .RST_N(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int w);
    for (int l = 0; l < P; l++) begin
      scnt[l*SW +: SW] = scnt_w[w][l];
      mem[l*MW +: MW]  = mem_w[w][l];
    end
  endtask

  task automatic drive_junk();
    for (int l = 0; l < P; l++) begin
      scnt[l*SW +: SW] = SW'($urandom);
      mem[l*MW +: MW]  = MW'($urandom);
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < P; l++) begin
        scnt_w[w][l] = SW'($urandom);
        mem_w[w][l]  = MW'($urandom);
      end
  endtask

  // Goodness = sum over all neurons of activity^2, activity = count or ReLU(mem).
  function automatic longint unsigned model_sum(input bit use_mem);
    longint unsigned s = 0;
    longint unsigned v;
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < P; l++) begin
        if (use_mem) v = mem_w[w][l][MW-1] ? 64'd0 : 64'(mem_w[w][l][MW-2:0]);
        else         v = 64'(scnt_w[w][l]);
        s += v * v;
      end
    return s;
  endfunction

  function automatic longint unsigned sat(input longint unsigned s, input int width);
    longint unsigned m = (64'd1 << width) - 64'd1;
    return (s > m) ? m : s;
  endfunction

  // One full sweep with checks on latency, result, hold and handshake.
  task automatic run_sweep(input string tag, input bit use_mem, input logic [31:0] thr_v,
                           input int gap_pct, input int extra, input int hold,
                           input bit poke_start);
    longint unsigned raw = model_sum(use_mem);
    logic [31:0] exp_a = 32'(sat(raw, 32));
    logic [19:0] exp_b = 20'(sat(raw, 20));
    logic exp_pos_a = (exp_a >= thr_v);
    logic exp_pos_b = (exp_b >= thr_v[19:0]);
    int w = 0;
    int guard = 0;
    int ex = extra;
    bit v;

    start = 1'b1; sel = use_mem; thr = thr_v;
    step();
    start = 1'b0; sel = 1'($urandom); thr = $urandom;
    vectors++;
    if (if_a.good_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b exp 1", tag, if_a.good_busy);
    end

    while (w < NW && guard < 4000) begin
      v = (int'($urandom_range(99)) >= gap_pct);
      in_valid = v;
      if (v) drive_word(w);
      else   drive_junk();
      step();
      if (v) w++;
      guard++;
    end
    vectors++;
    if (w != NW) begin
      miscompares++;
      $display("FAIL %s beat_feed: got %0d beats exp %0d", tag, w, NW);
    end

    for (int k = 1; k <= 4; k++) begin
      in_valid = (ex > 0);
      if (ex > 0) ex--;
      drive_junk();
      step();
      vectors++;
      if ({if_a.good_valid, if_b.good_valid} !== ((k < 4) ? 2'b00 : 2'b11)) begin
        miscompares++;
        $display("FAIL %s valid_latency cycle %0d: got %b exp %b", tag, k,
                 {if_a.good_valid, if_b.good_valid}, (k < 4) ? 2'b00 : 2'b11);
      end
    end

    vectors++;
    if (if_a.goodness !== exp_a) begin
      miscompares++;
      $display("FAIL %s goodness_a: got %0d exp %0d", tag, if_a.goodness, exp_a);
    end
    vectors++;
    if (if_b.goodness !== exp_b) begin
      miscompares++;
      $display("FAIL %s goodness_b: got %0h exp %0h", tag, if_b.goodness, exp_b);
    end
    vectors++;
    if ({if_a.good_pos, if_b.good_pos} !== {exp_pos_a, exp_pos_b}) begin
      miscompares++;
      $display("FAIL %s good_pos a/b: got %b exp %b", tag,
               {if_a.good_pos, if_b.good_pos}, {exp_pos_a, exp_pos_b});
    end
    vectors++;
    if (if_a.good_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_in_done: got %b exp 0", tag, if_a.good_busy);
    end

    for (int i = 0; i < hold; i++) begin
      in_valid = (ex > 0);
      if (ex > 0) ex--;
      drive_junk();
      start = poke_start && (i == hold / 2);
      step();
      start = 1'b0;
      vectors++;
      if ({if_a.good_valid, if_a.goodness, if_a.good_busy} !== {1'b1, exp_a, 1'b0}) begin
        miscompares++;
        $display("FAIL %s hold cycle %0d: got v=%b g=%0d busy=%b exp v=1 g=%0d busy=0",
                 tag, i, if_a.good_valid, if_a.goodness, if_a.good_busy, exp_a);
      end
    end
    in_valid = 1'b0;

    ready = 1'b1; start = poke_start;
    step();
    ready = 1'b0; start = 1'b0;
    vectors++;
    if ({if_a.good_valid, if_b.good_valid, if_a.good_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s handshake: got valid_a/valid_b/busy=%b exp 000", tag,
               {if_a.good_valid, if_b.good_valid, if_a.good_busy});
    end
    step();
    vectors++;
    if (if_a.good_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after_handshake: got busy=%b exp 0", tag, if_a.good_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1;
    step();
    step();
    vectors++;
    if ({if_a.goodness, if_a.good_pos, if_a.good_valid, if_a.good_busy,
         if_b.goodness, if_b.good_pos, if_b.good_valid, if_b.good_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got a g=%0h p=%b v=%b b=%b / b g=%0h p=%b v=%b b=%b exp all 0",
               if_a.goodness, if_a.good_pos, if_a.good_valid, if_a.good_busy,
               if_b.goodness, if_b.good_pos, if_b.good_valid, if_b.good_busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if ({if_a.good_valid, if_a.good_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL ready_in_idle: got valid/busy=%b exp 00", {if_a.good_valid, if_a.good_busy});
    end
    ready = 1'b0;
  endtask

  task automatic test_spike_sweep();
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < P; l++) begin
        scnt_w[w][l] = 7'd2;
        mem_w[w][l]  = MW'($urandom);
      end
    run_sweep("spike_sweep", 1'b0, 32'd1000, 0, 0, 0, 1'b0);
  endtask

  task automatic test_mem_relu();
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < P; l++) begin
        scnt_w[w][l] = SW'($urandom);
        mem_w[w][l]  = (w % 2 == 0) ? 12'h040 : 12'hFC0;
      end
    run_sweep("mem_relu", 1'b1, 32'd524289, 0, 0, 0, 1'b0);
  endtask

  task automatic test_bubbles_backpressure();
    fill_random();
    run_sweep("bubbles", 1'b1, $urandom, 30, 0, 10, 1'b1);
    fill_random();
    run_sweep("bubbles_next", 1'b0, 32'd20000, 40, 0, 2, 1'b0);
  endtask

  task automatic test_saturation();
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < P; l++) begin
        scnt_w[w][l] = SW'($urandom);
        mem_w[w][l]  = 12'h7FF;
      end
    run_sweep("saturation", 1'b1, 32'h000F_FFFF, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    fill_random();
    start = 1'b1; sel = 1'b0; thr = 32'd0;
    step();
    start = 1'b0;
    for (int w = 0; w <= 30; w++) begin
      in_valid = 1'b1;
      drive_word(w);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if ({if_a.goodness, if_a.good_pos, if_a.good_valid, if_a.good_busy,
         if_b.good_valid, if_b.good_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_sweep: got g=%0h p=%b v=%b b=%b vb=%b bb=%b exp all 0",
               if_a.goodness, if_a.good_pos, if_a.good_valid, if_a.good_busy,
               if_b.good_valid, if_b.good_busy);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      vectors++;
      if ({if_a.good_valid, if_b.good_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL aborted_sweep_valid cycle %0d: got %b exp 00", i,
                 {if_a.good_valid, if_b.good_valid});
      end
    end
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < P; l++) begin
        scnt_w[w][l] = 7'd1;
        mem_w[w][l]  = MW'($urandom);
      end
    run_sweep("fresh_after_reset", 1'b0, 32'd256, 0, 0, 0, 1'b0);
  endtask

  task automatic test_extra_beats();
    fill_random();
    run_sweep("extra_beats", 1'($urandom), $urandom, 0, 6, 4, 1'b0);
  endtask

  task automatic test_random();
    bit m;
    longint unsigned raw;
    for (int n = 0; n < 3; n++) begin
      fill_random();
      m = 1'($urandom);
      raw = model_sum(m);
      run_sweep("random", m, 32'(raw) + 32'($urandom_range(1)), $urandom_range(50), 0,
                $urandom_range(3), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_spike_sweep();
    test_mem_relu();
    test_bubbles_backpressure();
    test_saturation();
    test_reset_mid_sweep();
    test_extra_beats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
